rvfi_pc_seq_check: RTL and testbench
====================================

// Module: rvfi_pc_seq_check
// PURPOSE
// - Parametrised PC-continuity and retire-order checker on the RVFI trace bus; sits beside the DUT in formal and sim harnesses.
// - Tracks a shadow PC across NRET retire channels and checks, per retirement:
//   - pc_rdata equals the previous retirement's pc_wdata;
//   - rvfi_order increments by one;
//   - the next PC meets IALIGN.
// - Sticky error flags and a first-failure snapshot are exported as ports for harness/cover use.
// PARAMETERS
// - XLEN     32  Datapath/PC width (32 or 64).
// - NRET      1  Retire channels per cycle (1..8).
// - ORDER_W  64  Width of each rvfi_order field.
// - IALIGN   32  Instruction alignment: 32, or 16 when the C extension is present.
// - CNT_W    32  Width of the retire counter (saturating).
// PORTS
// - clk            in   1             Sole clock, rising edge.
// - resetn         in   1             Asynchronous active-low reset.
// - rvfi_valid     in   NRET          Retire valid, one bit per channel.
// - rvfi_order     in   NRET*ORDER_W  Retire index per channel.
// - rvfi_trap      in   NRET          Retirement trapped.
// - rvfi_pc_rdata  in   NRET*XLEN     PC of the retired instruction.
// - rvfi_pc_wdata  in   NRET*XLEN     Next PC.
// - err_pc         out  1             Sticky: PC discontinuity seen.
// - err_order      out  1             Sticky: order skip or repeat seen.
// - err_align      out  1             Sticky: misaligned next PC on a non-trapping retire.
// - err_any        out  1             OR of the three flags (combinational from the flops).
// - fail_order     out  ORDER_W       rvfi_order of the first failing retirement.
// - fail_pc_exp    out  XLEN          Shadow PC at the first PC failure.
// - fail_pc_got    out  XLEN          pc_rdata at the first PC failure.
// - retire_cnt     out  CNT_W         Valid retirements since reset; saturates at all-ones.
// BEHAVIOUR
// - Reset (async, resetn=0): all outputs, shadow PC, expected order and retire_cnt go to 0; state goes to UNSYNC.
// - FSM:
//   - UNSYNC: no reference yet.
//   - SYNC: shadow PC and expected order valid.
//   - FAILED: at least one error flag set.
//   - UNSYNC->SYNC on the first valid retirement. SYNC->FAILED on any error.
//   - FAILED keeps checking and updating the shadow. It exits only on reset.
// - Channels are processed in ascending index within one cycle. Channel k compares against the shadow as updated by valid channels < k.
// - Per valid retirement on channel k, in SYNC/FAILED:
//   - PC check: pc_rdata[k] != shadow sets err_pc.
//   - Order check: order[k] != exp_order sets err_order.
//   - Alignment check (only when rvfi_trap[k]=0):
//     - pc_wdata[k][0] != 0 always sets err_align;
//     - when IALIGN==32, pc_wdata[k][1] != 0 also sets it.
//   - Update: shadow <= pc_wdata[k]; exp_order <= order[k]+1, mod 2^ORDER_W (wrap is legal).
// - First valid retirement in UNSYNC:
//   - No PC or order check; the alignment check still applies.
//   - Shadow and exp_order are seeded from that retirement.
// - Snapshot: fail_* load only on the cycle the first error of any kind occurs (err_any rising).
//   - fail_order is the lowest failing channel's order.
//   - fail_pc_exp and fail_pc_got load only if that failure is a PC failure; otherwise they hold 0.
//   - After that, fail_* hold until reset.
// - Latency: flags, snapshot and retire_cnt update on the clock edge after the offending sample and are visible the next cycle.
// - retire_cnt adds popcount(rvfi_valid) per cycle and clamps at 2^CNT_W-1.
// - Holes: non-valid channels between valid ones are skipped and do not disturb the shadow.
// - Reset mid-trace: everything clears; the next retirement re-seeds with no error. An order discontinuity across reset is legal.
// CONFIGURATION
// - RISCV_FORMAL_PC_SEQ_ASSERT_EN defined:
//   - each error condition also fires an immediate assert(...) in the clocked block;
//   - the assert is gated by resetn and by the same check enable.
// - Undefined: no assert statements are emitted; errors are reported through the output ports only (simulator-neutral).
// TESTING
// - T1 NRET=1: retires pc 0x0->0x4, 0x4->0x8, orders 0,1 -> all err_* 0, retire_cnt=2.
// - T2 NRET=1: after a 0x4->0x8 retire, the next retire has pc_rdata=0xC, order 2
//   -> err_pc=1 next cycle; fail_pc_exp=0x8, fail_pc_got=0xC, fail_order=2.
// - T3 NRET=2, same cycle:
//   - ch0 0x10->0x14 ord 5, ch1 0x14->0x18 ord 6 -> no error;
//   - repeat with ch1 pc_rdata=0x18 -> err_pc=1, fail_order=6.
// - T4 IALIGN=32: non-trap retire with pc_wdata=0x102 -> err_align=1, fail_pc_exp=0;
//   - the same retire with trap=1 -> no error;
//   - IALIGN=16 with 0x102 -> no error.
// - T5 ORDER_W=8: orders 0xFF then 0x00 -> no error;
//   - orders 3 then 5 -> err_order=1, fail_order=5.
// - T6: err_pc set; assert resetn=0 mid-cycle (async)
//   -> all outputs 0 immediately; the next retire at arbitrary pc/order -> no error.

Source files
------------

// File: rtl/rvfi_pc_seq_check.sv
// PC-continuity / retire-order checker for the RVFI trace bus, with sticky flags and first-failure snapshot.
// Optional: define RISCV_FORMAL_PC_SEQ_ASSERT_EN to also fire immediate asserts on each error condition.
module rvfi_pc_seq_check #(
  parameter int XLEN    = 32,
  parameter int NRET    = 1,
  parameter int ORDER_W = 64,
  parameter int IALIGN  = 32,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET-1:0]         rvfi_trap,
  input  logic [NRET*XLEN-1:0]    rvfi_pc_rdata,
  input  logic [NRET*XLEN-1:0]    rvfi_pc_wdata,
  output logic                    err_pc,
  output logic                    err_order,
  output logic                    err_align,
  output logic                    err_any,
  output logic [ORDER_W-1:0]      fail_order,
  output logic [XLEN-1:0]         fail_pc_exp,
  output logic [XLEN-1:0]         fail_pc_got,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam logic [1:0] ST_UNSYNC = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_FAILED = 2'd2;

  logic [1:0]         r_state;
  logic [XLEN-1:0]    r_shadow;
  logic [ORDER_W-1:0] r_exp_order;
  logic               r_err_pc;
  logic               r_err_order;
  logic               r_err_align;
  logic [ORDER_W-1:0] r_fail_order;
  logic [XLEN-1:0]    r_fail_pc_exp;
  logic [XLEN-1:0]    r_fail_pc_got;
  logic [CNT_W-1:0]   r_retire_cnt;

  logic [XLEN-1:0]    w_shadow;
  logic [ORDER_W-1:0] w_exp_order;
  logic               w_synced;
  logic               w_hit_pc;
  logic               w_hit_order;
  logic               w_hit_align;
  logic               w_first_seen;
  logic [ORDER_W-1:0] w_first_order;
  logic [XLEN-1:0]    w_first_exp;
  logic [XLEN-1:0]    w_first_got;
  logic [XLEN-1:0]    w_rdata;
  logic [XLEN-1:0]    w_wdata;
  logic [ORDER_W-1:0] w_order;
  logic               w_pc_bad;
  logic               w_ord_bad;
  logic               w_al_bad;
  logic [3:0]         w_pop;
  logic               w_new_err;
  logic               w_rise;
  logic [1:0]         w_state_nxt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [3:0] b);
    logic [CNT_W+3:0] s;
    s = {4'b0, a} + (CNT_W+4)'(b);
    return (|s[CNT_W+3:CNT_W]) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  // Walk channels in ascending order; each sees the shadow as advanced by lower valid channels.
  always_comb begin
    w_shadow      = r_shadow;
    w_exp_order   = r_exp_order;
    w_synced      = (r_state != ST_UNSYNC);
    w_hit_pc      = 1'b0;
    w_hit_order   = 1'b0;
    w_hit_align   = 1'b0;
    w_first_seen  = 1'b0;
    w_first_order = '0;
    w_first_exp   = '0;
    w_first_got   = '0;
    w_rdata       = '0;
    w_wdata       = '0;
    w_order       = '0;
    w_pc_bad      = 1'b0;
    w_ord_bad     = 1'b0;
    w_al_bad      = 1'b0;
    w_pop         = '0;
    for (int k = 0; k < NRET; k++) begin
      if (rvfi_valid[k]) begin
        w_rdata   = rvfi_pc_rdata[k*XLEN +: XLEN];
        w_wdata   = rvfi_pc_wdata[k*XLEN +: XLEN];
        w_order   = rvfi_order[k*ORDER_W +: ORDER_W];
        w_pc_bad  = w_synced && (w_rdata != w_shadow);
        w_ord_bad = w_synced && (w_order != w_exp_order);
        w_al_bad  = !rvfi_trap[k] && (w_wdata[0] || ((IALIGN == 32) && w_wdata[1]));
        if (!w_first_seen && (w_pc_bad || w_ord_bad || w_al_bad)) begin
          w_first_seen  = 1'b1;
          w_first_order = w_order;
          if (w_pc_bad) begin
            w_first_exp = w_shadow;
            w_first_got = w_rdata;
          end
        end
        w_hit_pc    = w_hit_pc | w_pc_bad;
        w_hit_order = w_hit_order | w_ord_bad;
        w_hit_align = w_hit_align | w_al_bad;
        w_shadow    = w_wdata;
        w_exp_order = w_order + 1'b1;
        w_synced    = 1'b1;
        w_pop       = w_pop + 4'd1;
      end
    end
  end

  assign w_new_err = w_hit_pc | w_hit_order | w_hit_align;
  assign w_rise    = w_new_err && !err_any;

  always_comb begin
    w_state_nxt = r_state;
    if (err_any || w_new_err) w_state_nxt = ST_FAILED;
    else if (w_synced)        w_state_nxt = ST_SYNC;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_UNSYNC;
      r_shadow      <= '0;
      r_exp_order   <= '0;
      r_err_pc      <= 1'b0;
      r_err_order   <= 1'b0;
      r_err_align   <= 1'b0;
      r_fail_order  <= '0;
      r_fail_pc_exp <= '0;
      r_fail_pc_got <= '0;
      r_retire_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_shadow     <= w_shadow;
      r_exp_order  <= w_exp_order;
      r_err_pc     <= r_err_pc | w_hit_pc;
      r_err_order  <= r_err_order | w_hit_order;
      r_err_align  <= r_err_align | w_hit_align;
      r_retire_cnt <= sat_add(r_retire_cnt, w_pop);
      // Snapshot only the very first failure; later errors leave it untouched.
      if (w_rise) begin
        r_fail_order  <= w_first_order;
        r_fail_pc_exp <= w_first_exp;
        r_fail_pc_got <= w_first_got;
      end
`ifdef RISCV_FORMAL_PC_SEQ_ASSERT_EN
      assert (!(resetn && w_hit_pc))    else $error("rvfi_pc_seq_check: PC discontinuity");
      assert (!(resetn && w_hit_order)) else $error("rvfi_pc_seq_check: order skip or repeat");
      assert (!(resetn && w_hit_align)) else $error("rvfi_pc_seq_check: misaligned next PC");
`endif
    end
  end

  assign err_pc      = r_err_pc;
  assign err_order   = r_err_order;
  assign err_align   = r_err_align;
  assign err_any     = r_err_pc | r_err_order | r_err_align;
  assign fail_order  = r_fail_order;
  assign fail_pc_exp = r_fail_pc_exp;
  assign fail_pc_got = r_fail_pc_got;
  assign retire_cnt  = r_retire_cnt;

endmodule

// File: tb/tb_rvfi_pc_seq_check.sv
// Directed bench for rvfi_pc_seq_check: a two-channel 8-bit-order instance plus an IALIGN=16 instance.
module tb_rvfi_pc_seq_check;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  a_valid = '0;
  logic [15:0] a_order = '0;
  logic [1:0]  a_trap = '0;
  logic [63:0] a_rdata = '0;
  logic [63:0] a_wdata = '0;
  logic        a_err_pc, a_err_order, a_err_align, a_err_any;
  logic [7:0]  a_fail_order;
  logic [31:0] a_fail_pc_exp, a_fail_pc_got;
  logic [3:0]  a_cnt;

  logic        b_valid = 1'b0;
  logic [63:0] b_order = '0;
  logic        b_trap = 1'b0;
  logic [31:0] b_rdata = '0;
  logic [31:0] b_wdata = '0;
  logic        b_err_pc, b_err_order, b_err_align, b_err_any;
  logic [63:0] b_fail_order;
  logic [31:0] b_fail_pc_exp, b_fail_pc_got;
  logic [31:0] b_cnt;

  rvfi_pc_seq_check #(.XLEN(32), .NRET(2), .ORDER_W(8), .IALIGN(32), .CNT_W(4)) dut_a (
    .clk(clk), .resetn(resetn), .rvfi_valid(a_valid), .rvfi_order(a_order), .rvfi_trap(a_trap),
    .rvfi_pc_rdata(a_rdata), .rvfi_pc_wdata(a_wdata), .err_pc(a_err_pc), .err_order(a_err_order),
    .err_align(a_err_align), .err_any(a_err_any), .fail_order(a_fail_order),
    .fail_pc_exp(a_fail_pc_exp), .fail_pc_got(a_fail_pc_got), .retire_cnt(a_cnt));

  rvfi_pc_seq_check #(.XLEN(32), .NRET(1), .ORDER_W(64), .IALIGN(16), .CNT_W(32)) dut_b (
    .clk(clk), .resetn(resetn), .rvfi_valid(b_valid), .rvfi_order(b_order), .rvfi_trap(b_trap),
    .rvfi_pc_rdata(b_rdata), .rvfi_pc_wdata(b_wdata), .err_pc(b_err_pc), .err_order(b_err_order),
    .err_align(b_err_align), .err_any(b_err_any), .fail_order(b_fail_order),
    .fail_pc_exp(b_fail_pc_exp), .fail_pc_got(b_fail_pc_got), .retire_cnt(b_cnt));

  typedef struct {
    logic        e_pc;
    logic        e_ord;
    logic        e_al;
    logic [7:0]  fo;
    logic [31:0] fexp;
    logic [31:0] fgot;
    logic [3:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "/err_pc"}, 64'(a_err_pc), 64'd0);
    chk({tag, "/err_order"}, 64'(a_err_order), 64'd0);
    chk({tag, "/err_align"}, 64'(a_err_align), 64'd0);
    chk({tag, "/err_any"}, 64'(a_err_any), 64'd0);
    chk({tag, "/fail_order"}, 64'(a_fail_order), 64'd0);
    chk({tag, "/fail_pc_exp"}, 64'(a_fail_pc_exp), 64'd0);
    chk({tag, "/fail_pc_got"}, 64'(a_fail_pc_got), 64'd0);
    chk({tag, "/retire_cnt"}, 64'(a_cnt), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_valid = '0;
    b_valid = 1'b0;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  task automatic step(input string tag, input logic [1:0] v,
                      input logic [7:0] o0, input logic [31:0] r0, input logic [31:0] w0, input logic t0,
                      input logic [7:0] o1, input logic [31:0] r1, input logic [31:0] w1, input logic t1,
                      input logic epc, input logic eord, input logic eal, input logic [7:0] efo,
                      input logic [31:0] efexp, input logic [31:0] efgot, input logic [3:0] ecnt);
    exp_t e;
    @(negedge clk);
    a_valid = v;
    a_order = {o1, o0};
    a_rdata = {r1, r0};
    a_wdata = {w1, w0};
    a_trap  = {t1, t0};
    e.e_pc = epc; e.e_ord = eord; e.e_al = eal;
    e.fo = efo; e.fexp = efexp; e.fgot = efgot; e.cnt = ecnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    a_valid = '0;
    e = sb.pop_front();
    chk({tag, "/err_pc"}, 64'(a_err_pc), 64'(e.e_pc));
    chk({tag, "/err_order"}, 64'(a_err_order), 64'(e.e_ord));
    chk({tag, "/err_align"}, 64'(a_err_align), 64'(e.e_al));
    chk({tag, "/err_any"}, 64'(a_err_any), 64'(e.e_pc | e.e_ord | e.e_al));
    chk({tag, "/fail_order"}, 64'(a_fail_order), 64'(e.fo));
    chk({tag, "/fail_pc_exp"}, 64'(a_fail_pc_exp), 64'(e.fexp));
    chk({tag, "/fail_pc_got"}, 64'(a_fail_pc_got), 64'(e.fgot));
    chk({tag, "/retire_cnt"}, 64'(a_cnt), 64'(e.cnt));
  endtask

  task automatic step_b(input string tag, input logic [63:0] o, input logic [31:0] r, input logic [31:0] w,
                        input logic eal, input logic [63:0] efo, input logic [31:0] ecnt);
    @(negedge clk);
    b_valid = 1'b1;
    b_order = o;
    b_rdata = r;
    b_wdata = w;
    b_trap  = 1'b0;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    chk({tag, "/err_align"}, 64'(b_err_align), 64'(eal));
    chk({tag, "/err_any"}, 64'(b_err_any), 64'(eal));
    chk({tag, "/err_pc"}, 64'(b_err_pc), 64'd0);
    chk({tag, "/fail_order"}, b_fail_order, efo);
    chk({tag, "/retire_cnt"}, 64'(b_cnt), 64'(ecnt));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_a_zero("reset");
    chk("reset/b_cnt", 64'(b_cnt), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // T1 / T2: single-channel continuity then a PC break; FAILED keeps tracking the shadow.
    step("t1a", 2'b01, 8'd0, 32'h0, 32'h4, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd1);
    step("t1b", 2'b01, 8'd1, 32'h4, 32'h8, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd2);
    step("t2",  2'b01, 8'd2, 32'hC, 32'h10, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 1, 0, 0, 8'd2, 32'h8, 32'hC, 4'd3);
    step("t2h", 2'b01, 8'd3, 32'h10, 32'h14, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 1, 0, 0, 8'd2, 32'h8, 32'hC, 4'd4);

    // T3: two channels in one cycle.
    do_reset();
    step("t3a", 2'b11, 8'd5, 32'h10, 32'h14, 1'b0, 8'd6, 32'h14, 32'h18, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd2);
    do_reset();
    step("t3b", 2'b11, 8'd5, 32'h10, 32'h14, 1'b0, 8'd6, 32'h18, 32'h1C, 1'b0, 1, 0, 0, 8'd6, 32'h14, 32'h18, 4'd2);
    step("t3c", 2'b01, 8'd9, 32'h40, 32'h44, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 1, 1, 0, 8'd6, 32'h14, 32'h18, 4'd3);

    // T4: alignment, trap exemption, bit-0 misalignment.
    do_reset();
    step("t4a", 2'b01, 8'h20, 32'h100, 32'h102, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 1, 8'h20, 32'h0, 32'h0, 4'd1);
    do_reset();
    step("t4b", 2'b01, 8'h20, 32'h100, 32'h102, 1'b1, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'h0, 32'h0, 32'h0, 4'd1);
    step("t4c", 2'b01, 8'h21, 32'h102, 32'h105, 1'b1, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'h0, 32'h0, 32'h0, 4'd2);
    step("t4d", 2'b01, 8'h22, 32'h105, 32'h108, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'h0, 32'h0, 32'h0, 4'd3);
    step("t4e", 2'b01, 8'h23, 32'h108, 32'h109, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 1, 8'h23, 32'h0, 32'h0, 4'd4);

    // T5: order wrap is legal, a skip is not.
    do_reset();
    step("t5a", 2'b01, 8'hFF, 32'h0, 32'h4, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd1);
    step("t5b", 2'b01, 8'h00, 32'h4, 32'h8, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd2);
    do_reset();
    step("t5c", 2'b01, 8'd3, 32'h0, 32'h4, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd1);
    step("t5d", 2'b01, 8'd5, 32'h4, 32'h8, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 1, 0, 8'd5, 32'h0, 32'h0, 4'd2);

    // Holes: invalid channels carry garbage that must be ignored.
    do_reset();
    step("h1", 2'b10, 8'h77, 32'hDEAD0000, 32'h3, 1'b0, 8'd10, 32'h20, 32'h24, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd1);
    step("h2", 2'b01, 8'd11, 32'h24, 32'h28, 1'b0, 8'h99, 32'h0, 32'h1, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd2);

    // Counter saturation at 15 with two retirements per cycle.
    for (int i = 0; i < 7; i++) begin
      step("sat", 2'b11, 8'(12 + 2*i), 32'(32'h28 + 8*i), 32'(32'h2C + 8*i), 1'b0,
           8'(13 + 2*i), 32'(32'h2C + 8*i), 32'(32'h30 + 8*i), 1'b0,
           0, 0, 0, 8'd0, 32'h0, 32'h0, (i == 6) ? 4'd15 : 4'(4 + 2*i));
    end
    step("sat_hold", 2'b01, 8'd26, 32'h60, 32'h64, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd15);

    // T6: error, then asynchronous reset mid-cycle, then re-seed at an arbitrary point.
    step("t6e", 2'b01, 8'd27, 32'h99, 32'h9C, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 1, 0, 0, 8'd27, 32'h64, 32'h99, 4'd15);
    @(negedge clk);
    #1;
    resetn = 1'b0;
    #1;
    chk_a_zero("t6rst");
    #1;
    resetn = 1'b1;
    step("t6s", 2'b01, 8'h4D, 32'h500, 32'h504, 1'b0, 8'd0, 32'h0, 32'h0, 1'b0, 0, 0, 0, 8'd0, 32'h0, 32'h0, 4'd1);

    // IALIGN=16 instance: bit 1 is legal, bit 0 is not.
    step_b("b16a", 64'd7, 32'h0, 32'h102, 1'b0, 64'd0, 32'd1);
    step_b("b16b", 64'd8, 32'h102, 32'h101, 1'b1, 64'd8, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
